// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: widths, reset PC,
// NOP encoding and the fetch state encoding.
package fetch_stage_pkg;

  localparam int          FETCH_ADDR_W   = 32;
  localparam int          FETCH_DATA_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold (stall) beats flush, flush beats load, and
// anything else is a bubble that keeps the last pc_plus4.
import fetch_stage_pkg::*;

module if_id_reg #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              valid_o
);

  logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  // next-state selection for the IF/ID contents
  always_comb begin
    pc_plus4_d = pc_plus4_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    if (hold_i) begin
      pc_plus4_d = pc_plus4_q;
    end else if (flush_i) begin
      pc_plus4_d = {ADDR_W{1'b0}};
      inst_d     = DATA_W'(FETCH_NOP);
      valid_d    = 1'b0;
    end else if (load_i) begin
      pc_plus4_d = pc_plus4_i;
      inst_d     = inst_i;
      valid_d    = valid_i;
    end else begin
      inst_d     = DATA_W'(FETCH_NOP);
      valid_d    = 1'b0;
    end
  end

  // IF/ID state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_plus4_q <= {ADDR_W{1'b0}};
      inst_q     <= DATA_W'(FETCH_NOP);
      valid_q    <= 1'b0;
    end else begin
      pc_plus4_q <= pc_plus4_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_plus4_o = pc_plus4_q;
  assign inst_o     = inst_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, variable-latency imem handshake, IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN adds misalign_ID and word-aligns redirect targets.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_IF,
  input  logic              is_branch,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              is_rst_IF_ID,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_plus4_ID,
  output logic [DATA_W-1:0] inst_ID,
  output logic              valid_ID
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              misalign_ID
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, hold_pc4_q, hold_pc4_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
  logic              kill_q, kill_d, misal_q, misal_d, hold_misal_q, hold_misal_d;
  logic [ADDR_W-1:0] pc_plus4_s, target_s, ld_pc4_s;
  logic [DATA_W-1:0] ld_inst_s, ld_word_s;
  logic              ld_s, ld_valid_s, flush_s, misal_tgt_s;

  assign pc_plus4_s = pc_q + ADDR_W'(32'd4);

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_s    = {branch_address[ADDR_W-1:2], 2'b00};
  assign misal_tgt_s = |branch_address[1:0];
`else
  assign target_s    = branch_address;
  assign misal_tgt_s = 1'b0;
`endif

  // fetch FSM, PC/kill/hold-buffer next state and IF/ID load selection
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    misal_d      = misal_q;
    hold_pc4_d   = hold_pc4_q;
    hold_inst_d  = hold_inst_q;
    hold_misal_d = hold_misal_q;
    ld_s         = 1'b0;
    flush_s      = 1'b0;
    ld_pc4_s     = pc_plus4_s;
    ld_inst_s    = imem_rdata;
    ld_valid_s   = !misal_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (stall_IF) begin
          // a killed response is wrong-path data even while stalled
          if (imem_ack && kill_q) begin
            kill_d = 1'b0;
          end else if (imem_ack) begin
            hold_pc4_d   = pc_plus4_s;
            hold_inst_d  = imem_rdata;
            hold_misal_d = misal_q;
            state_d      = ST_HOLD;
          end else begin
            kill_d = kill_q;
          end
        end else begin
          flush_s = is_rst_IF_ID;
          if (is_branch) begin
            pc_d    = target_s;
            misal_d = misal_tgt_s;
            kill_d  = !imem_ack;
          end else if (imem_ack && kill_q) begin
            kill_d = 1'b0;
          end else if (imem_ack) begin
            ld_s    = 1'b1;
            pc_d    = pc_plus4_s;
            misal_d = 1'b0;
          end else begin
            ld_s = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (stall_IF) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_REQ;
          flush_s = is_rst_IF_ID;
          if (is_branch) begin
            pc_d    = target_s;
            misal_d = misal_tgt_s;
          end else begin
            ld_s       = 1'b1;
            ld_pc4_s   = hold_pc4_q;
            ld_inst_s  = hold_inst_q;
            ld_valid_s = !hold_misal_q;
            pc_d       = pc_plus4_s;
            misal_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // the request address only moves once the outstanding request completes
    if (state_q == ST_REQ && !imem_ack) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  assign ld_word_s = ld_valid_s ? ld_inst_s : DATA_W'(FETCH_NOP);

  // fetch state, PC, request address, kill flag and hold buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      kill_q       <= 1'b0;
      misal_q      <= 1'b0;
      hold_pc4_q   <= {ADDR_W{1'b0}};
      hold_inst_q  <= {DATA_W{1'b0}};
      hold_misal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      kill_q       <= kill_d;
      misal_q      <= misal_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_inst_q  <= hold_inst_d;
      hold_misal_q <= hold_misal_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = addr_q;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (stall_IF),
    .flush_i    (flush_s),
    .load_i     (ld_s),
    .valid_i    (ld_valid_s),
    .pc_plus4_i (ld_pc4_s),
    .inst_i     (ld_word_s),
    .pc_plus4_o (pc_plus4_ID),
    .inst_o     (inst_ID),
    .valid_o    (valid_ID)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // misalign flag travels with the IF/ID contents
  always_comb begin
    misalign_d = 1'b0;
    if (stall_IF) begin
      misalign_d = misalign_q;
    end else if (flush_s) begin
      misalign_d = 1'b0;
    end else if (ld_s) begin
      misalign_d = !ld_valid_s;
    end else begin
      misalign_d = 1'b0;
    end
  end

  // misalign flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_ID = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (default build).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_IF = 1'b0, is_branch = 1'b0, is_rst_IF_ID = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_address = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, valid_ID;
  logic [31:0] imem_addr, pc_plus4_ID, inst_ID;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_IF       (stall_IF),
    .is_branch      (is_branch),
    .branch_address (branch_address),
    .is_rst_IF_ID   (is_rst_IF_ID),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_plus4_ID    (pc_plus4_ID),
    .inst_ID        (inst_ID),
    .valid_ID       (valid_ID)
  );

  typedef struct {
    logic        stall, br, rif, ack;
    logic [31:0] ba, rdata;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_inst, e_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] ba,
                              input logic rif, input logic ack, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_inst, input logic [31:0] e_pc4);
    vec_t v;
    v.stall = stall; v.br = br; v.ba = ba; v.rif = rif; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc4);
    chk({tag, ".imem_req"},    {31'd0, imem_req}, {31'd0, e_req});
    chk({tag, ".imem_addr"},   imem_addr, e_addr);
    chk({tag, ".valid_ID"},    {31'd0, valid_ID}, {31'd0, e_valid});
    chk({tag, ".inst_ID"},     inst_ID, e_inst);
    chk({tag, ".pc_plus4_ID"}, pc_plus4_ID, e_pc4);
  endtask

  task automatic drive(input logic stall, input logic br, input logic [31:0] ba,
                       input logic rif, input logic ack, input logic [31:0] rdata);
    stall_IF = stall; is_branch = br; branch_address = ba;
    is_rst_IF_ID = rif; imem_ack = ack; imem_rdata = rdata;
  endtask

  initial begin
    // stall, br, ba, rif, ack, rdata | req, addr, valid, inst, pc4
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          0,32'h0,0,32'h0,0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_0000,  1,32'h0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_0004,  1,32'h4,1,32'h1000_0000,32'h4));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_0008,  1,32'h8,1,32'h1000_0004,32'h8));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'hC,1,32'h1000_0008,32'hC));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'hC,0,32'h0,32'hC));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_000C,  1,32'hC,0,32'h0,32'hC));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h10,1,32'h1000_000C,32'h10));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h10,0,32'h0,32'h10));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_0010,  1,32'h10,0,32'h0,32'h10));
    vecs.push_back(mk(0,1,32'h100,0,0,32'h0,        1,32'h14,1,32'h1000_0010,32'h14));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h14,0,32'h0,32'h14));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hDEAD_BEEF,  1,32'h14,0,32'h0,32'h14));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_0100,  1,32'h100,0,32'h0,32'h14));
    vecs.push_back(mk(0,1,32'h200,1,1,32'h1000_0104,1,32'h104,1,32'h1000_0100,32'h104));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1000_0200,  1,32'h200,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,32'h0,  1,32'h204,1,32'h1000_0200,32'h204));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h0BAD_0BAD,  1,32'h204,0,32'h0,32'h204));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h1FFF_FFFC,  1,32'hFFFF_FFFC,0,32'h0,32'h204));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h0,1,32'h1FFF_FFFC,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,          1,32'h0,0,32'h0,32'h0));

    // reset state
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    // fetch streaming, latency, redirect, flush, wrap
    for (int i = 0; i < vecs.size(); i++) begin
      chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_inst, vecs[i].e_pc4);
      drive(vecs[i].stall, vecs[i].br, vecs[i].ba, vecs[i].rif, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
    end

    // stall across an ack: held word delivered exactly once, branch ignored while stalled
    drive(0, 0, 32'h0, 0, 1, 32'h1000_0000);
    @(negedge clk);
    chk_out("stall.pre", 1'b1, 32'h4, 1'b1, 32'h1000_0000, 32'h4);
    drive(1, 0, 32'h0, 0, 1, 32'h2000_0004);
    @(negedge clk);
    chk("stall.hold_req", {31'd0, imem_req}, 32'h0);
    chk("stall.hold_inst", inst_ID, 32'h1000_0000);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h300, 1, 0, 32'h0);
      @(negedge clk);
      chk($sformatf("stall%0d.req", k), {31'd0, imem_req}, 32'h0);
      chk($sformatf("stall%0d.inst", k), inst_ID, 32'h1000_0000);
      chk($sformatf("stall%0d.valid", k), {31'd0, valid_ID}, 32'h1);
      chk($sformatf("stall%0d.pc4", k), pc_plus4_ID, 32'h4);
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk_out("stall.release", 1'b1, 32'h8, 1'b1, 32'h2000_0004, 32'h8);
    @(negedge clk);
    chk_out("stall.after", 1'b1, 32'h8, 1'b0, 32'h0, 32'h8);

    // asynchronous reset in HOLD, late ack ignored after release
    drive(0, 0, 32'h0, 0, 1, 32'h3000_0008);
    @(negedge clk);
    chk_out("hold.pre", 1'b1, 32'hC, 1'b1, 32'h3000_0008, 32'hC);
    drive(1, 0, 32'h0, 0, 1, 32'h3000_000C);
    @(negedge clk);
    chk("hold.req", {31'd0, imem_req}, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    chk_out("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(0, 0, 32'h0, 0, 1, 32'h4000_0000);
    @(negedge clk);
    chk_out("post_rst.fetch", 1'b1, 32'h4, 1'b1, 32'h4000_0000, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
